// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if
//   Bundles the request/grant handshake and mux-select signals that pass
//   between the four requesters and the round-robin arbiter.
//
//   Req     [3:0] : request lines, bit i is requester i (mux input In[i])
//   Gnt     [3:0] : registered grant, one-hot or zero
//   S       [1:0] : registered mux select, index of current or last owner
//   Busy          : high while the arbiter is in its GRANT state
//   Expired       : one-cycle pulse when a grant is revoked by timeout
//
//   Modports:
//     master : requester side (drives Req, observes the arbiter outputs)
//     slave  : arbiter side   (observes Req, drives the arbiter outputs)
interface mux4_rr_arbiter_if;
  logic [3:0] Req;
  logic [3:0] Gnt;
  logic [1:0] S;
  logic       Busy;
  logic       Expired;

  modport master (
    output Req,
    input  Gnt,
    input  S,
    input  Busy,
    input  Expired
  );

  modport slave (
    input  Req,
    output Gnt,
    output S,
    output Busy,
    output Expired
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin arbiter that shares one mux4to1 datapath among four
//   requesters. One requester is granted at a time; the mux select S follows
//   the granted index and holds the last owner's index while idle so the mux
//   path does not toggle. An owner keeps the grant until it drops its
//   request; there is no preemption.
//
//   Optional feature macro: MUX_ARB_TIMEOUT_EN
//     defined   : an 8-bit hold counter revokes any grant after MAX_HOLD
//                 cycles and pulses Expired for one cycle on revocation.
//     undefined : grants are unbounded, Expired is tied to 0, MAX_HOLD unused.
//
//   Parameters:
//     MAX_HOLD : maximum grant length in cycles with the timeout (2..255)
//
//   Ports:
//     Clk   : clock, rising edge
//     Reset : synchronous active-high reset
//     bus   : mux4_rr_arbiter_if.slave (Req in; Gnt, S, Busy, Expired out)
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  mux4_rr_arbiter_if.slave      bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux4_rr_arbiter: MAX_HOLD must lie in 2..255");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [1:0] r_owner;
  logic [1:0] r_s;
  logic [3:0] r_gnt;
  logic       r_busy;

  logic       w_any;
  logic [1:0] w_pick;
  logic       w_own_req;

  // First set request bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  // The loop walks from the farthest offset down so the nearest one wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                         input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  assign w_any     = |bus.Req;
  assign w_pick    = rr_pick(bus.Req, r_ptr);
  assign w_own_req = bus.Req[r_owner];

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] r_cnt;
  logic       r_expired;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_ptr     <= 2'd0;
      r_owner   <= 2'd0;
      r_s       <= 2'd0;
      r_gnt     <= 4'b0000;
      r_busy    <= 1'b0;
      r_cnt     <= 8'd0;
      r_expired <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner <= w_pick;
            r_gnt   <= 4'b0001 << w_pick;
            r_s     <= w_pick;
            r_ptr   <= w_pick + 2'd1;
            r_cnt   <= 8'd0;
            r_busy  <= 1'b1;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          // A release on the same edge as the limit wins: no Expired pulse.
          if (!w_own_req) begin
            r_gnt   <= 4'b0000;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_cnt == HOLD_LAST) begin
            r_gnt     <= 4'b0000;
            r_busy    <= 1'b0;
            r_expired <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.Expired = r_expired;
`else
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_ptr   <= 2'd0;
      r_owner <= 2'd0;
      r_s     <= 2'd0;
      r_gnt   <= 4'b0000;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner <= w_pick;
            r_gnt   <= 4'b0001 << w_pick;
            r_s     <= w_pick;
            r_ptr   <= w_pick + 2'd1;
            r_busy  <= 1'b1;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (!w_own_req) begin
            r_gnt   <= 4'b0000;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.Expired = 1'b0;
`endif

  assign bus.Gnt  = r_gnt;
  assign bus.S    = r_s;
  assign bus.Busy = r_busy;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter
//   Directed bench for mux4_rr_arbiter (MAX_HOLD = 4). Inputs change 1 time
//   unit after a rising edge; outputs are sampled at the same point, after
//   the edge's registered updates have settled.
module tb_mux4_rr_arbiter;

  logic Clk;
  logic Reset;
  int   total;
  int   bad;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] gnt,
                         input logic [1:0] s, input logic busy,
                         input logic expired);
    chk({tag, ".Gnt"},     32'(bus.Gnt),     32'(gnt));
    chk({tag, ".S"},       32'(bus.S),       32'(s));
    chk({tag, ".Busy"},    32'(bus.Busy),    32'(busy));
    chk({tag, ".Expired"}, 32'(bus.Expired), 32'(expired));
  endtask

  initial begin
    logic [1:0] cur;
    logic [1:0] nxt;
    int         np_len;
    total = 0;
    bad   = 0;

    // Reset held two cycles with all requests up
    Reset   = 1'b1;
    bus.Req = 4'b1111;
    tick();
    chk_out("rst0", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk_out("rst1", 4'b0000, 2'd0, 1'b0, 1'b0);
    Reset = 1'b0;
    tick();
    chk_out("first_gnt", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Round robin 0,1,2,3,0: each owner holds 3 cycles then drops for 1
    cur = 2'd0;
    for (int n = 0; n < 4; n++) begin
      nxt = cur + 2'd1;
      tick();
      chk_out("rr_hold1", 4'b0001 << cur, cur, 1'b1, 1'b0);
      tick();
      chk_out("rr_hold2", 4'b0001 << cur, cur, 1'b1, 1'b0);
      bus.Req = 4'b1111 & ~(4'b0001 << cur);
      tick();
      chk_out("rr_idle", 4'b0000, cur, 1'b0, 1'b0);
      bus.Req = 4'b1111;
      tick();
      chk_out("rr_next", 4'b0001 << nxt, nxt, 1'b1, 1'b0);
      cur = nxt;
    end

    // Wrap and skip: bring Ptr to 3 via a grant to 2, then Req=0101
    bus.Req = 4'b0000;
    tick();
    chk_out("ws_idle0", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.Req = 4'b0100;
    tick();
    chk_out("ws_g2", 4'b0100, 2'd2, 1'b1, 1'b0);
    bus.Req = 4'b0000;
    tick();
    bus.Req = 4'b0101;
    tick();
    chk_out("ws_wrap", 4'b0001, 2'd0, 1'b1, 1'b0);
    bus.Req = 4'b0000;
    tick();
    chk_out("ws_idle1", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.Req = 4'b0101;
    tick();
    chk_out("ws_skip", 4'b0100, 2'd2, 1'b1, 1'b0);

    // No preemption: owner 1 holds while requester 0 asks
    bus.Req = 4'b0000;
    tick();
    bus.Req = 4'b0010;
    tick();
    chk_out("np_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
    bus.Req = 4'b0011;
`ifdef MUX_ARB_TIMEOUT_EN
    np_len = 2;
`else
    np_len = 4;
`endif
    for (int n = 0; n < np_len; n++) begin
      tick();
      chk_out("np_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    bus.Req = 4'b0001;
    tick();
    chk_out("np_rel", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick();
    chk_out("np_g0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Timeout: move Ptr to 0 via a grant to 3, then hold Req=0011
    bus.Req = 4'b0000;
    tick();
    bus.Req = 4'b1000;
    tick();
    chk_out("to_g3", 4'b1000, 2'd3, 1'b1, 1'b0);
    bus.Req = 4'b0000;
    tick();
    bus.Req = 4'b0011;
    tick();
    chk_out("to_g0", 4'b0001, 2'd0, 1'b1, 1'b0);
`ifdef MUX_ARB_TIMEOUT_EN
    for (int n = 0; n < 3; n++) begin
      tick();
      chk_out("to_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    tick();
    chk_out("to_expire", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    chk_out("to_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
`else
    for (int n = 0; n < 12; n++) begin
      tick();
      chk_out("to_nolimit", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
`endif

    // Reset mid-grant, then re-grant one cycle after release
    bus.Req = 4'b0000;
    tick();
    bus.Req = 4'b0100;
    tick();
    chk_out("mr_g2", 4'b0100, 2'd2, 1'b1, 1'b0);
    Reset = 1'b1;
    tick();
    chk_out("mr_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    Reset = 1'b0;
    tick();
    chk_out("mr_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
